// File: rtl/shift_accum_ctrl.sv
// Row sequencer for the column-strobed transposed-conv shift/accumulate datapath.
// Accepts one input block per row, walks the column strobe, captures and hands off the result.
module shift_accum_ctrl #(
   parameter int unsigned BIT_WIDTH     = 8,
   parameter int unsigned N_COL_FEATURE = 8,
   parameter int unsigned N_COL_KERNEL  = 5,
   parameter int unsigned NUM_STRIDE    = 2,
   parameter int unsigned N_ROWS        = 4,
   parameter int unsigned DRAIN_MAX     = 16,
   localparam int unsigned N_PIX_IN   = N_COL_FEATURE * N_COL_KERNEL,
   localparam int unsigned N_PIX_OUT  = N_COL_FEATURE * N_COL_KERNEL
                                        - (N_COL_KERNEL - NUM_STRIDE) * (N_COL_FEATURE - 1),
   localparam int unsigned STRB_WIDTH = 2 * BIT_WIDTH * N_PIX_IN / 4,
   localparam int unsigned DIN_W      = 2 * BIT_WIDTH * N_PIX_IN,
   localparam int unsigned DOUT_W     = 2 * BIT_WIDTH * N_PIX_OUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN_W-1:0]      in_data,
   output logic                  sr_en_shift,
   output logic [STRB_WIDTH-1:0] sr_data_strobe,
   output logic [DIN_W-1:0]      sr_data_in,
   output logic                  sr_rst_n,
   input  logic [DOUT_W-1:0]     sr_data_out,
   input  logic                  sr_accum_fin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_W-1:0]     out_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned COL_W  = (N_COL_FEATURE > 1) ? $clog2(N_COL_FEATURE) : 1;
   localparam int unsigned ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int unsigned DCNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_IN = 3'd1,
      SHIFT   = 3'd2,
      DRAIN   = 3'd3,
      OUT     = 3'd4,
      CLEAR   = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
   logic                  captured_q, captured_d;
   logic                  fin_take;
   logic                  err_d, done_d;
   logic [DIN_W-1:0]      data_in_d;
   logic [DOUT_W-1:0]     out_data_d;
   logic                  in_ready_d, en_shift_d, sr_rst_n_d, out_valid_d, busy_d;
   logic [STRB_WIDTH-1:0] strobe_d;

   // Next state, datapath registers and the registered-output values derived from the next state
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      dcnt_d     = dcnt_q;
      captured_d = captured_q;
      err_d      = err;
      done_d     = 1'b0;
      data_in_d  = sr_data_in;
      out_data_d = out_data;

      // Only the first completion flag of a row is taken
      fin_take = sr_accum_fin && !captured_q && ((state_q == SHIFT) || (state_q == DRAIN));
      if (fin_take) begin
         out_data_d = sr_data_out;
         captured_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               row_d   = '0;
               state_d = WAIT_IN;
            end
         end
         WAIT_IN: begin
            if (in_valid && in_ready) begin
               data_in_d  = in_data;
               col_d      = '0;
               captured_d = 1'b0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (col_q == COL_W'(N_COL_FEATURE - 1)) begin
               dcnt_d  = '0;
               state_d = captured_d ? OUT : DRAIN;
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         DRAIN: begin
            if (fin_take) begin
               state_d = OUT;
            end else if (dcnt_q == DCNT_W'(DRAIN_MAX - 1)) begin
               err_d   = 1'b1;
               state_d = CLEAR;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         OUT: begin
            if (out_ready) state_d = CLEAR;
         end
         CLEAR: begin
            row_d = row_q + ROW_W'(1);
            if (row_q == ROW_W'(N_ROWS - 1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT_IN;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == WAIT_IN);
      en_shift_d  = (state_d == SHIFT);
      strobe_d    = en_shift_d ? (STRB_WIDTH'(1) << col_d) : '0;
      sr_rst_n_d  = (state_d != CLEAR);
      out_valid_d = (state_d == OUT);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         row_q          <= '0;
         col_q          <= '0;
         dcnt_q         <= '0;
         captured_q     <= 1'b0;
         err            <= 1'b0;
         done           <= 1'b0;
         sr_data_in     <= '0;
         out_data       <= '0;
         in_ready       <= 1'b0;
         sr_en_shift    <= 1'b0;
         sr_data_strobe <= '0;
         sr_rst_n       <= 1'b0;
         out_valid      <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         col_q          <= col_d;
         dcnt_q         <= dcnt_d;
         captured_q     <= captured_d;
         err            <= err_d;
         done           <= done_d;
         sr_data_in     <= data_in_d;
         out_data       <= out_data_d;
         in_ready       <= in_ready_d;
         sr_en_shift    <= en_shift_d;
         sr_data_strobe <= strobe_d;
         sr_rst_n       <= sr_rst_n_d;
         out_valid      <= out_valid_d;
         busy           <= busy_d;
      end
   end

endmodule

// File: doc/shift_accum_ctrl.md
Name: shift_accum_ctrl

Overview:
- Sequencer for the column-strobed transposed-conv shift/accumulate datapath.
- Per feature row: accepts one input block over a valid/ready handshake and holds it on the datapath input bus.
- Walks a one-hot column strobe with en_shift, captures the accumulated row when the datapath flags completion, presents it over a valid/ready output handshake, then clears the datapath before the next row.
- Sits between the row-fetch logic upstream and the output writer downstream.

Parameters:
- BIT_WIDTH, 8: bits per pixel half-word; pixels carried as 2*BIT_WIDTH.
- N_COL_FEATURE, 8: feature columns per row; strobe steps per row.
- N_COL_KERNEL, 5: kernel columns.
- NUM_STRIDE, 2: stride.
- N_PIX_IN, N_COL_FEATURE*N_COL_KERNEL: pixels per input block.
- N_PIX_OUT, N_COL_FEATURE*N_COL_KERNEL-(N_COL_KERNEL-NUM_STRIDE)*(N_COL_FEATURE-1): pixels per output row.
- STRB_WIDTH, 2*BIT_WIDTH*N_PIX_IN/4: datapath strobe width.
- N_ROWS, 4: rows per job (>=1).
- DRAIN_MAX, 16: cycles to wait for completion after the last strobe.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; honoured only in IDLE.
- in_valid  in  1  input block valid.
- in_ready  out  1  controller accepts block.
- in_data  in  2*BIT_WIDTH*N_PIX_IN  input block.
- sr_en_shift  out  1  datapath shift enable.
- sr_data_strobe  out  STRB_WIDTH  one-hot column strobe.
- sr_data_in  out  2*BIT_WIDTH*N_PIX_IN  registered copy of the accepted block.
- sr_rst_n  out  1  datapath clear, active low.
- sr_data_out  in  2*BIT_WIDTH*N_PIX_OUT  datapath result.
- sr_accum_fin  in  1  datapath completion flag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  2*BIT_WIDTH*N_PIX_OUT  captured result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky drain-timeout flag.

Behaviour:
- Reset: state=IDLE. All outputs 0 except sr_rst_n=0 while rst_n low and 1 afterwards. Registers zero.
- States: IDLE, WAIT_IN, SHIFT, DRAIN, OUT, CLEAR.
- IDLE:
  - start=1 → clear err, row=0, go WAIT_IN.
  - start while busy is ignored.
- WAIT_IN:
  - in_ready=1.
  - On in_valid&in_ready, register in_data into sr_data_in (held stable until the next accept), col=0, captured=0, go SHIFT.
- SHIFT (exactly N_COL_FEATURE cycles):
  - sr_en_shift=1, sr_data_strobe=1<<col (upper bits 0), col increments each cycle.
  - After col=N_COL_FEATURE-1, go OUT if captured, else DRAIN with dcnt=0.
- Capture rule:
  - In SHIFT or DRAIN, on the first cycle of a row where sr_accum_fin=1, register sr_data_out into out_data and set captured=1.
  - Later assertions in the same row are ignored.
- DRAIN:
  - sr_en_shift=0, strobe=0.
  - sr_accum_fin=1 → capture and go OUT next cycle.
  - dcnt==DRAIN_MAX-1 without a capture → set err, go CLEAR (no output).
- OUT:
  - out_valid=1, with out_data stable while out_valid&!out_ready.
  - On out_ready, go CLEAR.
- CLEAR (1 cycle):
  - sr_rst_n=0, row increments.
  - If row==N_ROWS-1 before the increment: done=1, go IDLE. Otherwise go WAIT_IN.
- Latency: an accepted block reaches out_valid no earlier than N_COL_FEATURE+1 cycles after the in handshake.
- sr_en_shift and sr_data_strobe are registered outputs. The strobe is never multi-hot and is always 0 outside SHIFT.
- in_ready is 0 outside WAIT_IN. out_valid is 0 outside OUT.
- Async reset mid-job returns to IDLE immediately, drops out_valid and busy, and issues no done.
- err stays high until the next accepted start.

Test Plan:
- Single row: N_ROWS=1, start, in_valid with in_data pattern, accum_fin model asserting after 7 strobes → strobes 0x01..0x80 on consecutive cycles with en_shift=1; out_data equals model sr_data_out; one sr_rst_n low cycle; done pulse; busy falls.
- Backpressure: hold out_ready=0 for 5 cycles → out_valid stays 1, out_data stable, no CLEAR until out_ready=1.
- Late fin: model asserts fin 3 cycles after SHIFT ends → DRAIN for 3 cycles, capture, OUT; err=0.
- Timeout: fin never asserts → err=1 after DRAIN_MAX cycles, no out_valid, CLEAR, next row proceeds; err clears on the next start.
- Four rows with in_valid gaps of 0 and 3 cycles → exactly 4 out handshakes, 4 clears, one done; start pulsed mid-job is ignored.
- Reset asserted during SHIFT col=4 → strobe=0, en_shift=0, busy=0 immediately; a fresh start runs a full row correctly.
